// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared CPU types and constants for the fetch and decode stages.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP = 32'h00000013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Synchronous FIFO of fetch_entry_t with flush and head output.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           wdata,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t   r_mem [DEPTH];
  logic [AW-1:0]  r_wptr;
  logic [AW-1:0]  r_rptr;
  logic [AW:0]    r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (push) r_wptr <= r_wptr + 1'b1;
      if (pop)  r_rptr <= r_rptr + 1'b1;
      case ({push, pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked solely by r_count.
  // When full, wptr==rptr: a simultaneous push overwrites the slot being popped.
  always_ff @(posedge clk) begin
    if (push && !flush) r_mem[r_wptr] <= wdata;
  end

  assign head  = r_mem[r_rptr];
  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Fetch stage owning the PC, buffering {pc, instr} pairs for decode.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc_plus4
);

  localparam int              CW        = $clog2(DEPTH) + 1;
  localparam logic [XLEN-1:0] c_pc_step = XLEN'(4);
  localparam logic [CW-1:0]   c_depth   = CW'(DEPTH);

  logic [XLEN-1:0] r_fetch_pc;
  logic [CW-1:0]   w_count;
  logic            w_valid;
  logic            w_push;
  logic            w_pop;
  fetch_entry_t    w_wdata;
  fetch_entry_t    w_head;

  // Redirect suppresses both sides: the head is discarded by the flush, not consumed.
  assign w_valid = (w_count != '0);
  assign w_pop   = w_valid & out_ready & ~redirect_valid;
  assign w_push  = rst & ~redirect_valid & ((w_count < c_depth) | w_pop);

  assign w_wdata.pc    = r_fetch_pc;
  assign w_wdata.instr = imem_rdata;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .flush (redirect_valid),
    .wdata (w_wdata),
    .head  (w_head),
    .count (w_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
    end else if (w_push) begin
      r_fetch_pc <= r_fetch_pc + c_pc_step;
    end
  end

  assign imem_addr    = r_fetch_pc;
  assign out_valid    = w_valid;
  assign out_instr    = w_valid ? w_head.instr : '0;
  assign out_pc       = w_valid ? w_head.pc : '0;
  assign out_pc_plus4 = w_valid ? (w_head.pc + c_pc_step) : '0;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_queue
// Description : Directed, table-driven self-checking bench for fetch_queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

  typedef struct {
    logic        r;
    logic        rdy;
    logic        rd;
    logic [31:0] rpc;
    logic        v;
    logic [31:0] pc;
    logic [31:0] addr;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;

  int   checks;
  int   failures;
  vec_t vecs[$];

  // Instruction memory image: word 3, word 5 (custom-0 CNN op), word 15 preset.
  function automatic logic [31:0] m(input logic [5:0] i);
    case (i)
      6'd3:    return 32'h002030ab;
      6'd5:    return 32'h0221000b;
      6'd15:   return 32'h00119133;
      default: return {8'hc0, 18'h0, i};
    endcase
  endfunction

  assign imem_rdata = m(imem_addr[7:2]);

  fetch_queue #(
    .XLEN     (32),
    .DEPTH    (4),
    .RESET_PC (32'h00000000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_pc_plus4   (out_pc_plus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic rdy, input logic rd, input logic [31:0] rpc,
                     input logic v, input logic [31:0] pc, input logic [31:0] addr);
    vec_t t;
    t.r = r; t.rdy = rdy; t.rd = rd; t.rpc = rpc; t.v = v; t.pc = pc; t.addr = addr;
    vecs.push_back(t);
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] pc,
                         input logic [31:0] addr);
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    e_instr = v ? m(pc[7:2]) : 32'h0;
    e_pc4   = v ? pc + 32'd4 : 32'h0;
    chk({tag, " valid"}, {31'h0, out_valid}, {31'h0, v});
    chk({tag, " pc"}, out_pc, v ? pc : 32'h0);
    chk({tag, " instr"}, out_instr, e_instr);
    chk({tag, " pc4"}, out_pc_plus4, e_pc4);
    chk({tag, " addr"}, imem_addr, addr);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;

    //  r  rdy rd  rpc           v  pc            addr
    add(0, 1, 0, 32'h0,         0, 32'h0,        32'h0);         // 0 in reset
    add(1, 1, 0, 32'h0,         0, 32'h0,        32'h0);         // 1 release
    add(1, 1, 0, 32'h0,         1, 32'h0,        32'h4);         // 2
    add(1, 1, 0, 32'h0,         1, 32'h4,        32'h8);         // 3
    add(1, 1, 0, 32'h0,         1, 32'h8,        32'hc);         // 4
    add(1, 1, 0, 32'h0,         1, 32'hc,        32'h10);        // 5 word 3
    add(0, 0, 0, 32'h0,         0, 32'h0,        32'h0);         // 6 reset again
    add(1, 0, 0, 32'h0,         0, 32'h0,        32'h0);         // 7 backpressure
    add(1, 0, 0, 32'h0,         1, 32'h0,        32'h4);         // 8
    add(1, 0, 0, 32'h0,         1, 32'h0,        32'h8);         // 9
    add(1, 0, 0, 32'h0,         1, 32'h0,        32'hc);         // 10
    add(1, 0, 0, 32'h0,         1, 32'h0,        32'h10);        // 11 full
    add(1, 0, 0, 32'h0,         1, 32'h0,        32'h10);        // 12 hold
    add(1, 1, 0, 32'h0,         1, 32'h0,        32'h10);        // 13 full + pop
    add(1, 0, 0, 32'h0,         1, 32'h4,        32'h14);        // 14
    add(1, 0, 0, 32'h0,         1, 32'h4,        32'h14);        // 15 still full
    add(1, 1, 0, 32'h0,         1, 32'h4,        32'h14);        // 16 drain
    add(1, 1, 0, 32'h0,         1, 32'h8,        32'h18);        // 17
    add(1, 1, 0, 32'h0,         1, 32'hc,        32'h1c);        // 18
    add(1, 1, 0, 32'h0,         1, 32'h10,       32'h20);        // 19
    add(1, 1, 0, 32'h0,         1, 32'h14,       32'h24);        // 20 CNN op
    add(1, 0, 1, 32'h3e,        1, 32'h18,       32'h28);        // 21 redirect full
    add(1, 1, 0, 32'h0,         0, 32'h0,        32'h3c);        // 22
    add(1, 1, 0, 32'h0,         1, 32'h3c,       32'h40);        // 23
    add(1, 1, 1, 32'h81,        1, 32'h40,       32'h44);        // 24 redirect, ready
    add(1, 1, 0, 32'h0,         0, 32'h0,        32'h80);        // 25
    add(1, 1, 1, 32'h20,        1, 32'h80,       32'h84);        // 26 back-to-back
    add(1, 1, 1, 32'h30,        0, 32'h0,        32'h20);        // 27
    add(1, 1, 0, 32'h0,         0, 32'h0,        32'h30);        // 28
    add(1, 1, 1, 32'hffffffff,  1, 32'h30,       32'h34);        // 29 to top of space
    add(1, 1, 0, 32'h0,         0, 32'h0,        32'hfffffffc);  // 30
    add(1, 1, 0, 32'h0,         1, 32'hfffffffc, 32'h0);         // 31 pc wraps
    add(1, 1, 0, 32'h0,         1, 32'h0,        32'h4);         // 32

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      rst            = vecs[i].r;
      out_ready      = vecs[i].rdy;
      redirect_valid = vecs[i].rd;
      redirect_pc    = vecs[i].rpc;
      @(negedge clk);
      chk_out($sformatf("row%0d", i), vecs[i].v, vecs[i].pc, vecs[i].addr);
      @(posedge clk);
      #1;
    end

    // Asynchronous reset with three entries queued.
    rst = 1'b0;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_out("q3", 1'b1, 32'h0, 32'hc);
    #2;
    rst = 1'b0;
    #1;
    chk_out("async", 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk_out("rst0", 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk_out("rst1", 1'b1, 32'h0, 32'h4);
    @(negedge clk);
    chk_out("rst2", 1'b1, 32'h4, 32'h8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
